fir_coef_ctrl: RTL and testbench

Coefficient configuration and sequencing controller for the 16-tap synchronous FIR datapath. It accepts coefficient writes from a host-side valid/ready port into a shadow bank. On a commit it swaps the shadow bank into the active bank at a sample boundary. It then holds the FIR output invalid until the delay line and output register have refilled with samples processed under the new coefficient set. It sits between the configuration bus and the FIR, and drives the FIR's coefficient inputs and an output-qualify strobe.

---
 rtl/fir_ctrl_pkg.sv | 24 ++
 rtl/fir_coef_bank.sv | 52 +++++
 rtl/fir_coef_ctrl.sv | 109 ++++++++++
 tb/tb_fir_coef_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient controller.
//   - Default tap count and coefficient width.
//   - Controller state encoding.
//   - Flush-counter width, sized so the counter can hold TAPS+1.
package fir_ctrl_pkg;

  localparam int TAPS_DEF   = 16;
  localparam int COEF_W_DEF = 8;

  // The flush counter must reach TAPS (delay stages) and then step once more
  // for the output register, so it needs room for TAPS+1.
  function automatic int flush_cnt_width(input int taps);
    return $clog2(taps + 1);
  endfunction

  localparam int CNT_W_DEF = $clog2(TAPS_DEF + 1);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair.
//   clk, rst   : clock and synchronous active-high reset (both banks clear)
//   wr_en      : write shadow[wr_addr] = wr_data this edge
//   wr_addr    : tap index
//   wr_data    : coefficient value
//   swap       : copy the whole shadow bank into the active bank this edge
//   coef_flat  : active bank, tap k at bits [k*COEF_W +: COEF_W]
module fir_coef_bank #(
  parameter int TAPS   = 16,
  parameter int COEF_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [COEF_W-1:0]      wr_data,
  input  logic                   swap,
  output logic [TAPS*COEF_W-1:0] coef_flat
);

  logic [COEF_W-1:0] shadow [TAPS];
  logic [COEF_W-1:0] active [TAPS];

  // The swap reads the shadow value from before this edge; the controller
  // never writes and swaps on the same edge, so there is no ordering hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_addr] <= wr_data;
      end
      if (swap) begin
        for (int k = 0; k < TAPS; k++) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  always_comb begin
    coef_flat = '0;
    for (int k = 0; k < TAPS; k++) begin
      coef_flat[k*COEF_W +: COEF_W] = active[k];
    end
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient configuration and sequencing controller for a TAPS-tap FIR.
// Host writes go into a shadow bank; a commit swaps it into the active bank at
// the next sample boundary, then out_valid is held low until the delay line
// and output register have refilled under the new coefficients.
//   clk, rst    : clock, synchronous active-high reset
//   cfg_valid   : host presents a write beat
//   cfg_ready   : controller can accept a beat (low only while a commit pends)
//   cfg_addr    : tap index
//   cfg_data    : coefficient value
//   cfg_last    : beat also commits the shadow bank (data written first)
//   sample_en   : FIR shifts a new sample this cycle
//   coef_flat   : active bank, tap k at bits [k*COEF_W +: COEF_W]
//   out_valid   : FIR output reflects only the active bank
//   commit_done : one-cycle pulse on the cycle after the bank swap
//   busy        : high while pending or flushing
//   state       : controller state, for observation
//   flush_cnt   : samples seen since the last swap/reset, for observation
//
// Handshake: a beat transfers on the rising edge where cfg_valid && cfg_ready.
// cfg_ready is decoded from registered state only and never looks at
// cfg_valid, so the host may hold cfg_valid and wait.
module fir_coef_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [ADDR_W-1:0]                 cfg_addr,
  input  logic [COEF_W-1:0]                 cfg_data,
  input  logic                              cfg_last,
  input  logic                              sample_en,
  output logic [TAPS*COEF_W-1:0]            coef_flat,
  output logic                              out_valid,
  output logic                              commit_done,
  output logic                              busy,
  output state_t                            state,
  output logic [flush_cnt_width(TAPS)-1:0]  flush_cnt
);

  localparam int CNT_W = flush_cnt_width(TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic xfer;
  logic commit;
  logic swap;

  assign cfg_ready = (state != ST_PEND);
  assign out_valid = (state == ST_RUN);
  assign busy      = (state != ST_RUN);

  assign xfer   = cfg_valid && cfg_ready;
  assign commit = xfer && cfg_last;
  assign swap   = (state == ST_PEND) && sample_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FLUSH;
      flush_cnt   <= '0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (commit) state <= ST_PEND;
        end
        ST_FLUSH: begin
          // A new commit abandons the refill; the count restarts at the swap.
          if (commit) begin
            state <= ST_PEND;
          end else if (sample_en) begin
            // Reaching TAPS means the delay line is full; this pulse also
            // loads the output register, so the output is now clean.
            if (flush_cnt == CNT_LAST) state <= ST_RUN;
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ST_PEND: begin
          if (sample_en) begin
            state       <= ST_FLUSH;
            flush_cnt   <= '0;
            commit_done <= 1'b1;
          end
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

  fir_coef_bank #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (xfer),
    .wr_addr   (cfg_addr),
    .wr_data   (cfg_data),
    .swap      (swap),
    .coef_flat (coef_flat)
  );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl: directed scenarios plus random traffic,
// checked against a bank/commit/sample-count model and a swap scoreboard.
module tb_fir_coef_ctrl;
  import fir_ctrl_pkg::*;

  localparam int TAPS   = 16;
  localparam int COEF_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;
  localparam int FW     = TAPS * COEF_W;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_last;
  logic              sample_en;
  logic [FW-1:0]     coef_flat;
  logic              out_valid;
  logic              commit_done;
  logic              busy;
  state_t            state;
  logic [CNT_W-1:0]  flush_cnt;

  fir_coef_ctrl #(.TAPS(TAPS), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .sample_en   (sample_en),
    .coef_flat   (coef_flat),
    .out_valid   (out_valid),
    .commit_done (commit_done),
    .busy        (busy),
    .state       (state),
    .flush_cnt   (flush_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and check helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Banks as arrays; a commit is "pending" until the next sample; m_since counts
  // samples taken since the last swap/reset, capped at TAPS+1 (full refill).
  logic [COEF_W-1:0] m_shadow [TAPS];
  logic [COEF_W-1:0] m_active [TAPS];
  bit                m_pending = 0;
  int                m_since   = 0;
  bit                m_done    = 0;
  bit                m_live    = 0;
  logic [FW-1:0]     exp_q [$];

  function automatic logic [FW-1:0] flat_of(input logic [COEF_W-1:0] b [TAPS]);
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < TAPS; k++) r[k*COEF_W +: COEF_W] = b[k];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        m_shadow[k] = '0;
        m_active[k] = '0;
      end
      m_pending = 0;
      m_since   = 0;
      m_done    = 0;
      exp_q.delete();
      m_live    = 1;
    end else if (m_live) begin
      m_done = 0;
      if (m_pending) begin
        if (sample_en) begin
          for (int k = 0; k < TAPS; k++) m_active[k] = m_shadow[k];
          m_pending = 0;
          m_since   = 0;
          m_done    = 1;
        end
      end else begin
        if (cfg_valid) m_shadow[cfg_addr] = cfg_data;
        if (cfg_valid && cfg_last) begin
          m_pending = 1;
          exp_q.push_back(flat_of(m_shadow));
        end else if (sample_en && m_since < TAPS + 1) begin
          m_since++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (m_live) begin
      bit     e_valid;
      state_t e_state;
      logic [FW-1:0] e_bank;
      e_valid = !m_pending && (m_since == TAPS + 1);
      e_state = m_pending ? ST_PEND : (e_valid ? ST_RUN : ST_FLUSH);
      chk("out_valid", FW'(out_valid), FW'(e_valid));
      chk("cfg_ready", FW'(cfg_ready), FW'(!m_pending));
      chk("busy", FW'(busy), FW'(!e_valid));
      chk("commit_done", FW'(commit_done), FW'(m_done));
      chk("coef_flat", coef_flat, flat_of(m_active));
      chk_i("state", int'(state), int'(e_state));
      if (!m_pending) chk_i("flush_cnt", int'(flush_cnt), m_since);
      if (commit_done) begin
        if (exp_q.size() == 0) begin
          chk_i("swap_unexpected", 1, 0);
        end else begin
          e_bank = exp_q.pop_front();
          chk("swap_bank", coef_flat, e_bank);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One handshaked beat; called and returns at a falling edge.
  task automatic beat(input int a, input int d, input bit l);
    bit ok;
    ok = 0;
    cfg_valid = 1'b1;
    cfg_addr  = ADDR_W'(a);
    cfg_data  = COEF_W'(d);
    cfg_last  = l;
    for (int i = 0; i < 200; i++) begin
      if (cfg_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (!ok) chk_i("beat_timeout", 1, 0);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (commit_done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk_i("commit_timeout", 1, 0);
  endtask

  // Falling edges until out_valid rises, bounded.
  task automatic low_cycles(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [FW-1:0] ref_bank;
  int n;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_last = 1'b0; sample_en = 1'b1;

    // Reset fill: out_valid after exactly 17 samples, banks stay zero.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    low_cycles(n);
    chk_i("reset_fill_latency", n, 17);
    chk("reset_fill_bank", coef_flat, '0);
    idle(3);

    // Full load 1..16 with commit on tap 15.
    ref_bank = '0;
    for (int k = 0; k < TAPS; k++) begin
      beat(k, k + 1, k == TAPS - 1);
      ref_bank[k*COEF_W +: COEF_W] = COEF_W'(k + 1);
    end
    wait_done();
    low_cycles(n);
    chk_i("full_load_latency", n, 17);
    chk("full_load_bank", coef_flat, ref_bank);
    idle(3);

    // Deferred swap: commit while samples are stopped.
    sample_en = 1'b0;
    beat(3, 77, 1);
    idle(10);
    chk_i("deferred_state", int'(state), int'(ST_PEND));
    chk("deferred_ready", FW'(cfg_ready), FW'(1'b0));
    chk("deferred_bank", coef_flat, ref_bank);
    sample_en = 1'b1;
    @(negedge clk);
    chk("deferred_swap", FW'(commit_done), FW'(1'b1));
    ref_bank[3*COEF_W +: COEF_W] = 8'd77;
    chk("deferred_bank_after", coef_flat, ref_bank);
    idle(20);

    // Partial update of one tap.
    beat(4, 200, 1);
    wait_done();
    ref_bank[4*COEF_W +: COEF_W] = 8'd200;
    chk("partial_bank", coef_flat, ref_bank);
    idle(20);

    // Commit during flush restarts the refill.
    beat(0, 9, 1);
    wait_done();
    idle(5);
    beat(1, 55, 1);
    wait_done();
    low_cycles(n);
    chk_i("reflush_latency", n, 17);
    ref_bank[0 +: COEF_W] = 8'd9;
    ref_bank[1*COEF_W +: COEF_W] = 8'd55;
    chk("reflush_bank", coef_flat, ref_bank);
    idle(3);

    // Beat presented on the swap cycle lands in shadow only.
    sample_en = 1'b0;
    beat(5, 11, 1);
    sample_en = 1'b1;
    beat(6, 66, 0);
    idle(25);
    ref_bank[5*COEF_W +: COEF_W] = 8'd11;
    chk("swap_cycle_beat_bank", coef_flat, ref_bank);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      sample_en = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_addr  = ADDR_W'($urandom_range(0, TAPS - 1));
      cfg_data  = COEF_W'($urandom_range(0, 255));
      cfg_last  = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 200) == 0);
      @(negedge clk);
    end
    rst = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; sample_en = 1'b1;
    idle(25);

    // Reset in the middle of a flush with a write on the same edge.
    beat(7, 99, 1);
    wait_done();
    idle(3);
    cfg_valid = 1'b1; cfg_addr = 4'd8; cfg_data = 8'd123; cfg_last = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_bank", coef_flat, '0);
    chk_i("midreset_state", int'(state), int'(ST_FLUSH));
    chk_i("midreset_cnt", int'(flush_cnt), 0);
    chk("midreset_done", FW'(commit_done), FW'(1'b0));
    rst = 1'b0; cfg_valid = 1'b0;
    low_cycles(n);
    chk_i("midreset_fill_latency", n, 17);
    beat(9, 1, 1);
    wait_done();
    ref_bank = '0;
    ref_bank[9*COEF_W +: COEF_W] = 8'd1;
    chk("midreset_shadow_cleared", coef_flat, ref_bank);
    idle(20);

    chk_i("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
